// File: rtl/inject_arbiter.sv
// Round-robin arbiter that stamps and pushes one local flit at a time into the router inject port.
// Latency: grant sampled in IDLE, push_j one cycle later, src_ack one cycle after the sampled push_j_ack.
// Backpressure: no grant while j_e=0; push_j is held until push_j_ack, and the flit is never dropped.
module inject_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              X_cur,
    input  logic [2:0]              Y_cur,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [64*NUM_SRC-1:0]   src_flit,
    output logic [NUM_SRC-1:0]      src_ack,
    input  logic                    j_e,
    input  logic                    push_j_ack,
    output logic [63:0]             inject,
    output logic                    push_j,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             inj_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_PUSH, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [63:0]          inject_q, inject_d;
    logic                 push_q, push_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic [2:0]           gid_q, gid_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [TW-1:0]        wait_q, wait_d, wait_inc;
    logic                 terr_q, terr_d;
    logic [15:0]          inj_count_q, inj_count_d;

    // Sources are zero-extended to the 8-slot maximum so a 3-bit index always fits.
    logic [7:0]           req_ext;
    logic [511:0]         flit_ext;
    logic [3:0]           cand;
    logic [2:0]           sel;
    logic                 found;
    logic [63:0]          sel_flit;
    logic [63:0]          stamped;

    assign req_ext  = 8'(src_req);
    assign flit_ext = 512'(src_flit);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, ptr_q} + 4'(i);
            if (cand >= 4'(NUM_SRC)) begin
                cand = cand - 4'(NUM_SRC);
            end
            if (!found && req_ext[cand[2:0]]) begin
                found = 1'b1;
                sel   = cand[2:0];
            end
        end
        sel_flit        = flit_ext[{sel, 6'd0} +: 64];
        stamped         = sel_flit;
        stamped[57:52]  = {X_cur, Y_cur};
    end

    assign wait_inc = (wait_q == TMAX) ? wait_q : wait_q + TW'(1);

    always_comb begin
        state_d     = state_q;
        inject_d    = inject_q;
        push_d      = push_q;
        ack_d       = '0;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        wait_d      = wait_q;
        terr_d      = terr_q;
        inj_count_d = inj_count_q;
        case (state_q)
            ST_IDLE: begin
                if (found && j_e) begin
                    state_d  = ST_PUSH;
                    inject_d = stamped;
                    push_d   = 1'b1;
                    gid_d    = sel;
                    wait_d   = '0;
                end
            end
            ST_PUSH: begin
                wait_d = wait_inc;
                if (wait_inc == TMAX) begin
                    terr_d = 1'b1;
                end
                if (push_j_ack) begin
                    state_d     = ST_DONE;
                    push_d      = 1'b0;
                    ack_d       = NUM_SRC'(8'd1 << gid_q);
                    ptr_d       = (gid_q == 3'(NUM_SRC - 1)) ? 3'd0 : gid_q + 3'd1;
                    inj_count_d = inj_count_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            inject_q    <= '0;
            push_q      <= 1'b0;
            ack_q       <= '0;
            gid_q       <= '0;
            ptr_q       <= '0;
            wait_q      <= '0;
            terr_q      <= 1'b0;
            inj_count_q <= '0;
        end else begin
            state_q     <= state_d;
            inject_q    <= inject_d;
            push_q      <= push_d;
            ack_q       <= ack_d;
            gid_q       <= gid_d;
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            terr_q      <= terr_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign inject      = inject_q;
    assign push_j      = push_q;
    assign src_ack     = ack_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;
    assign inj_count   = inj_count_q;

endmodule

// File: tb/tb_inject_arbiter.sv
// Directed bench for inject_arbiter: a transaction-level model checked every cycle plus literal checks.
module tb_inject_arbiter;
    localparam int N  = 4;
    localparam int TO = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       X_cur = 3'd2;
    logic [2:0]       Y_cur = 3'd5;
    logic [N-1:0]     src_req = '0;
    logic [64*N-1:0]  src_flit = '0;
    logic [N-1:0]     src_ack;
    logic             j_e = 1'b1;
    logic             push_j_ack = 1'b0;
    logic [63:0]      inject;
    logic             push_j;
    logic [2:0]       grant_id;
    logic             busy;
    logic             timeout_err;
    logic [15:0]      inj_count;

    inject_arbiter #(.NUM_SRC(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .X_cur(X_cur), .Y_cur(Y_cur),
        .src_req(src_req), .src_flit(src_flit), .src_ack(src_ack),
        .j_e(j_e), .push_j_ack(push_j_ack), .inject(inject), .push_j(push_j),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one outstanding flit at a time; phase 0 waiting, 1 offered to router, 2 acknowledging.
    int           m_phase = 0;
    int           m_ptr = 0;
    int           m_wait = 0;
    logic         e_push = 1'b0;
    logic [63:0]  e_inject = '0;
    logic [2:0]   e_gid = '0;
    logic [N-1:0] e_ack = '0;
    logic         e_terr = 1'b0;
    logic [15:0]  e_cnt = '0;
    logic [15:0]  cnt_ofs = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_ptr = 0; m_wait = 0;
            e_push = 1'b0; e_inject = '0; e_gid = '0; e_ack = '0;
            e_terr = 1'b0; e_cnt = '0;
        end else begin
            e_ack = '0;
            if (m_phase == 0) begin
                if (j_e && src_req != '0) begin
                    int w;
                    logic [63:0] f;
                    bit hit;
                    hit = 0; w = 0;
                    for (int i = 0; i < N; i++) begin
                        if (!hit && src_req[(m_ptr + i) % N]) begin
                            hit = 1; w = (m_ptr + i) % N;
                        end
                    end
                    f        = src_flit[w*64 +: 64];
                    e_inject = {f[63:58], X_cur, Y_cur, f[51:0]};
                    e_gid    = 3'(w);
                    e_push   = 1'b1;
                    m_wait   = 0;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                m_wait++;
                if (m_wait >= TO) e_terr = 1'b1;
                if (push_j_ack) begin
                    m_phase = 2;
                    e_push  = 1'b0;
                    e_ack   = N'(1 << e_gid);
                    m_ptr   = (int'(e_gid) + 1) % N;
                    e_cnt   = e_cnt + 16'd1;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("push_j", push_j, e_push);
        chk("inject", inject, e_inject);
        chk("grant_id", grant_id, e_gid);
        chk("src_ack", src_ack, e_ack);
        chk("busy", busy, m_phase != 0);
        chk("timeout_err", timeout_err, e_terr);
        chk("inj_count", inj_count, 16'(e_cnt + cnt_ofs));
    end

    int ack_seen [N];
    initial for (int i = 0; i < N; i++) ack_seen[i] = 0;
    always @(negedge clk) for (int i = 0; i < N; i++) if (src_ack[i]) ack_seen[i]++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base [N];
        src_flit[0*64 +: 64] = 64'hFC00_0000_0000_00AA;
        src_flit[1*64 +: 64] = 64'h0C00_1111_2222_3333;
        src_flit[2*64 +: 64] = 64'h8000_AAAA_BBBB_CCCC;
        src_flit[3*64 +: 64] = 64'h43F0_0000_DEAD_BEEF;

        cyc(2);
        chk("rst_push_j", push_j, 0);
        chk("rst_inject", inject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inj_count", inj_count, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b1;
        cyc(1);

        // Single source: X=2,Y=5 land in bits 57:52 as 6'b010101.
        src_req = 4'b0001; push_j_ack = 1'b1;
        cyc(1);
        chk("single_push_j", push_j, 1);
        chk("single_inject", inject, 64'hFD50_0000_0000_00AA);
        cyc(1);
        chk("single_src_ack", src_ack, 4'b0001);
        chk("single_push_low", push_j, 0);
        chk("single_count", inj_count, 1);
        src_req = '0;
        cyc(2);

        // Round robin from a fresh pointer.
        do_reset();
        for (int i = 0; i < N; i++) base[i] = ack_seen[i];
        src_req = 4'b1111; push_j_ack = 1'b1;
        for (int g = 0; g < 8; g++) begin
            cyc(1);
            chk("rr_grant", grant_id, 3'(g % N));
            chk("rr_push", push_j, 1);
            cyc(2);
        end
        src_req = '0;
        for (int i = 0; i < N; i++) chk("rr_ack_count", 64'(ack_seen[i] - base[i]), 2);
        cyc(2);

        // Back-pressure: nothing pushed while the router buffer is occupied.
        j_e = 1'b0; src_req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk("bp_no_push", push_j, 0);
        end
        j_e = 1'b1;
        cyc(1);
        chk("bp_push", push_j, 1);
        chk("bp_grant", grant_id, 2);
        chk("bp_inject", inject, 64'h8150_AAAA_BBBB_CCCC);
        cyc(1);
        src_req = '0;
        cyc(2);

        // Timeout: ack withheld for 300 PUSH cycles; j_e toggling mid-push is ignored.
        push_j_ack = 1'b0; src_req = 4'b0010;
        cyc(1);
        chk("to_grant", grant_id, 1);
        for (int c = 1; c <= 300; c++) begin
            chk("to_push_held", push_j, 1);
            if (c == 255) chk("to_err_before", timeout_err, 0);
            if (c == 256) chk("to_err_after", timeout_err, 1);
            if (c == 100) j_e = 1'b0;
            if (c == 200) j_e = 1'b1;
            if (c == 300) push_j_ack = 1'b1;
            cyc(1);
        end
        chk("to_src_ack", src_ack, 4'b0010);
        chk("to_err_sticky", timeout_err, 1);
        chk("to_push_low", push_j, 0);
        src_req = '0; push_j_ack = 1'b0;
        cyc(2);

        // Reset asserted mid-push clears outputs without waiting for a clock edge.
        src_req = 4'b0001;
        cyc(1);
        chk("rmp_push", push_j, 1);
        cyc(1);
        #2 reset = 1'b0;
        #1;
        chk("rmp_push_j", push_j, 0);
        chk("rmp_inject", inject, 0);
        chk("rmp_busy", busy, 0);
        chk("rmp_count", inj_count, 0);
        chk("rmp_timeout", timeout_err, 0);
        cyc(1);
        reset = 1'b1; src_req = '0;
        cyc(3);
        chk("rmp_no_ack", src_ack, 0);
        chk("rmp_count_after", inj_count, 0);

        // Counter wrap: preload near the top and inject two flits.
        dut.inj_count_q = 16'hFFFE;
        cnt_ofs = 16'hFFFE;
        src_req = 4'b1000; push_j_ack = 1'b1;
        cyc(2);
        chk("wrap_ffff", inj_count, 16'hFFFF);
        cyc(3);
        chk("wrap_zero", inj_count, 16'h0000);
        cyc(1);
        src_req = '0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
